// File: rtl/demux_dispatcher.sv
// One-entry dispatcher in front of an 8-lane demux: picks a lane per word
// (addressed or round-robin over dest_mask) and holds the word until that lane accepts it.
module demux_dispatcher #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_dest,
  input  logic          mode,
  input  logic [7:0]    dest_mask,
  output logic [7:0]    out_valid,
  input  logic [7:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_sel,
  output logic          err,
  output logic [7:0]    drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_data;
  logic [2:0]    r_sel;
  logic [2:0]    r_rr_ptr;
  logic          r_err;
  logic [7:0]    r_drop_cnt;

  logic          w_mask_block;
  logic          w_sel_ready;
  logic          w_accept;
  logic          w_drop;
  logic          w_load;
  logic [2:0]    w_rr_pick;
  logic          w_rr_found;
  logic [2:0]    w_pick;

  // Round-robin with an empty mask has nowhere to send a word, so stall the producer.
  assign w_mask_block = mode && (dest_mask == 8'h00);
  assign w_sel_ready  = out_ready[r_sel];
  assign in_ready     = !w_mask_block && ((r_state == IDLE) || w_sel_ready);
  assign w_accept     = in_valid && in_ready;
  assign w_drop       = w_accept && !mode && !dest_mask[in_dest];
  assign w_load       = w_accept && !w_drop;

  always_comb begin
    logic [2:0] idx;
    w_rr_pick  = r_rr_ptr;
    w_rr_found = 1'b0;
    idx        = r_rr_ptr;
    for (int k = 1; k <= 8; k++) begin
      idx = r_rr_ptr + 3'(k);
      if (!w_rr_found && dest_mask[idx]) begin
        w_rr_pick  = idx;
        w_rr_found = 1'b1;
      end
    end
  end

  assign w_pick = mode ? w_rr_pick : in_dest;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_load) w_state_next = HOLD;
      HOLD: if (w_sel_ready && !w_load) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_sel      <= 3'd0;
      r_rr_ptr   <= 3'd7;
      r_err      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_drop;
      if (w_load) begin
        r_data <= in_data;
        r_sel  <= w_pick;
      end
      if (w_accept && mode) begin
        r_rr_ptr <= w_rr_pick;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_valid
    assign out_valid[gi] = (r_state == HOLD) && (r_sel == 3'(gi));
  end

  assign out_data = r_data;
  assign out_sel  = r_sel;
  assign err      = r_err;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: doc/demux_dispatcher.md
# demux_dispatcher

Sequenced front end for the 1-to-8 demultiplexer datapath. Accepts a stream of data words on a valid/ready input, selects one of eight destinations per word (explicit address or round-robin over an enable mask), and holds each word in a one-entry output register. The registered select drives the one-hot output valids, and the word waits there until the chosen destination accepts it. Sits between a single producer and eight consumer lanes sharing one data bus.

## Interface
- DW, 8, data word width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  dispatcher accepts the word this cycle
- in_data  input  DW  word
- in_dest  input  3  destination index, used when mode=0
- mode  input  1  0 = addressed, 1 = round-robin
- dest_mask  input  8  per-destination enable; bit i=1 means lane i may receive
- out_valid  output  8  one-hot valid; bit out_sel set while a word is held
- out_ready  input  8  per-lane accept
- out_data  output  DW  held word, shared by all lanes
- out_sel  output  3  index of the lane currently addressed
- err  output  1  one-cycle pulse when a word is dropped
- drop_cnt  output  8  count of dropped words, saturating at 255

## Operation
- Two states:
  - IDLE: output register empty.
  - HOLD: one word held; out_valid[out_sel]=1, all other bits 0.
- Accept = in_valid & in_ready.
- in_ready:
  - In IDLE: 1, except in mode=1 with dest_mask=0, where it is 0.
  - In HOLD: out_ready[out_sel], with the same mask=0 exception.
- Destination pick at accept:
  - mode=0: in_dest.
  - mode=1: first index with dest_mask=1, searching cyclically from rr_ptr+1 (wraps 7 to 0).
- rr_ptr (3 bits) updates to the picked index only on a round-robin accept. It is unchanged in mode=0.
- Addressed drop: mode=0 with dest_mask[in_dest]=0.
  - The word is accepted and discarded, and err pulses the next cycle.
  - drop_cnt increments, holding at 255.
  - The state transition is as if no word was accepted.
- Transitions:
  - IDLE with a non-drop accept: go to HOLD and load out_data and out_sel.
  - HOLD with out_ready[out_sel] and a non-drop accept in the same cycle: stay in HOLD and reload (back-to-back, one word per cycle).
  - HOLD with out_ready[out_sel] and no non-drop accept: go to IDLE.
  - HOLD without out_ready[out_sel]: stay; out_data and out_sel are stable.
- out_ready bits other than out_sel are ignored.
- Changes to mode or dest_mask while in HOLD never alter the held word or out_sel. They affect only the next pick.
- In IDLE, out_data and out_sel keep their last values. Only out_valid goes to 0.

## Timing
- Reset values (asynchronous assert; deassert is synchronous to clk):
  - state IDLE, out_valid=0, out_data=0, out_sel=0, rr_ptr=7 (so the first round-robin pick is lane 0), err=0, drop_cnt=0.
- Latency: a word accepted at edge N is presented with out_valid set after edge N, and can be consumed at edge N+1.
- Throughput: one word per clock while the addressed lane keeps out_ready high.
- in_ready depends combinationally on out_ready, mode and dest_mask. All other outputs are registered.
- err is registered: it is high for exactly the one cycle after the dropping edge.
- Reset mid-HOLD: the held word is lost, out_valid clears immediately, and no err pulse is produced.

## Test plan
- Reset then addressed mode (mode=0, mask=0xFF): send in_dest=5, data=0xA5 with all out_ready=1 -> out_valid=0x20, out_data=0xA5 for one cycle; in_ready stays 1.
- Round-robin with mask=0x29: send 4 back-to-back words with all out_ready=1 -> out_sel sequence 0,3,5,0; out_valid 0x01,0x08,0x20,0x01 on consecutive cycles.
- Backpressure: hold out_ready[2]=0 for 5 cycles with a word for lane 2 held and in_valid=1 -> in_ready=0, out_data and out_sel stable. Raise out_ready[2] -> the held word transfers and the next word loads in the same cycle.
- Drop: mode=0, mask=0xFB, in_dest=2, then 300 such words -> no out_valid, err pulses once per word, drop_cnt ends at 255.
- Round-robin with mask=0x00 -> in_ready=0. Set mask=0x80 mid-stall -> the next word goes to lane 7.
- Assert rst_n=0 during HOLD with out_ready=0 -> out_valid=0 immediately. After release, the first round-robin pick with mask=0xFF is lane 0.
